// File: rtl/tx_medida_serial.sv
// tx_medida_serial: sends one angle/distance sample as the ASCII record
// "AAA,DDD#" over a 7E2 UART line (start, 7 data LSB first, even parity,
// two stop bits). Digits are latched at the start so inputs may move freely
// while the record is on the wire.
//
// Handshake: partida is a start request taken only when the sequencer is
// idle (inicial) or just finishing (final, for back-to-back records when
// partida is held high); ocupado is high while a record is on the line and
// pronto pulses for one cycle when the last stop bit has completed.
module tx_medida_serial #(
  parameter int BAUD_DIV = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       partida,
  input  logic [3:0] angulo_centena,
  input  logic [3:0] angulo_dezena,
  input  logic [3:0] angulo_unidade,
  input  logic [3:0] medida_centena,
  input  logic [3:0] medida_dezena,
  input  logic [3:0] medida_unidade,
  output logic       saida_serial,
  output logic       ocupado,
  output logic       pronto,
  output logic [3:0] db_estado
);

  typedef enum logic [3:0] {
    INICIAL   = 4'd0,
    REGISTRA  = 4'd1,
    CARREGA   = 4'd2,
    TRANSMITE = 4'd3,
    PROXIMO   = 4'd4,
    FINAL     = 4'd5
  } estado_t;

  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  estado_t       estado, proximo_estado;
  logic [2:0]    indice;
  logic [3:0]    bit_cnt;
  logic [CW-1:0] baud_cnt;
  logic [3:0]    ang_c, ang_d, ang_u, med_c, med_d, med_u;
  logic [10:0]   quadro_sr;
  logic [6:0]    caractere;
  logic [10:0]   quadro;
  logic          fim_bit, fim_quadro;

  // BCD digit to 7-bit ASCII; anything that is not a decimal digit becomes '?'
  function automatic logic [6:0] bcd_ascii(input logic [3:0] d);
    return (d > 4'd9) ? 7'h3F : (7'h30 + {3'b000, d});
  endfunction

  assign fim_bit    = (baud_cnt == BAUD_LAST);
  assign fim_quadro = fim_bit && (bit_cnt == 4'd10);

  // Select the character for the current record position
  always_comb begin
    caractere = 7'h23;
    case (indice)
      3'd0: caractere = bcd_ascii(ang_c);
      3'd1: caractere = bcd_ascii(ang_d);
      3'd2: caractere = bcd_ascii(ang_u);
      3'd3: caractere = 7'h2C;
      3'd4: caractere = bcd_ascii(med_c);
      3'd5: caractere = bcd_ascii(med_d);
      3'd6: caractere = bcd_ascii(med_u);
      default: caractere = 7'h23;
    endcase
  end

  // Full 11-bit frame, bit 0 goes on the line first
  assign quadro = {2'b11, ^caractere, caractere, 1'b0};

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= INICIAL;
    else       estado <= proximo_estado;
  end

  // Next-state logic
  always_comb begin
    proximo_estado = estado;
    case (estado)
      INICIAL:   if (partida) proximo_estado = REGISTRA;
      REGISTRA:  proximo_estado = CARREGA;
      CARREGA:   proximo_estado = TRANSMITE;
      // The last character goes straight to final so pronto lands on the
      // cycle right after its final stop bit.
      TRANSMITE: if (fim_quadro) proximo_estado = (indice == 3'd7) ? FINAL : PROXIMO;
      PROXIMO:   proximo_estado = (indice == 3'd7) ? FINAL : CARREGA;
      FINAL:     proximo_estado = partida ? REGISTRA : INICIAL;
      default:   proximo_estado = INICIAL;
    endcase
  end

  // Status outputs decoded from the state
  always_comb begin
    ocupado   = (estado == CARREGA) || (estado == TRANSMITE) || (estado == PROXIMO);
    pronto    = (estado == FINAL);
    db_estado = estado;
  end

  // Datapath: digit latch, character index, baud/bit counters, shifter, line
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      saida_serial <= 1'b1;
      quadro_sr    <= '1;
      indice       <= 3'd0;
      bit_cnt      <= 4'd0;
      baud_cnt     <= '0;
      ang_c <= 4'd0; ang_d <= 4'd0; ang_u <= 4'd0;
      med_c <= 4'd0; med_d <= 4'd0; med_u <= 4'd0;
    end else begin
      case (estado)
        REGISTRA: begin
          ang_c  <= angulo_centena;
          ang_d  <= angulo_dezena;
          ang_u  <= angulo_unidade;
          med_c  <= medida_centena;
          med_d  <= medida_dezena;
          med_u  <= medida_unidade;
          indice <= 3'd0;
        end
        CARREGA: begin
          saida_serial <= quadro[0];
          quadro_sr    <= {1'b1, quadro[10:1]};
          baud_cnt     <= '0;
          bit_cnt      <= 4'd0;
        end
        TRANSMITE: begin
          if (fim_bit) begin
            // After the last stop bit the shifter only holds fill ones, so the
            // line returns to idle high.
            baud_cnt     <= '0;
            bit_cnt      <= bit_cnt + 4'd1;
            saida_serial <= quadro_sr[0];
            quadro_sr    <= {1'b1, quadro_sr[10:1]};
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        PROXIMO: indice <= indice + 3'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_medida_serial.sv
// Bench for tx_medida_serial: a fast instance (BAUD_DIV=4) for the record,
// latch, handshake and reset cases, and a full-rate instance (BAUD_DIV=434)
// for the invalid-digit and bit-width case. A UART monitor per instance
// decodes frames and compares them against the expected-character queues.
module tb_tx_medida_serial;
  localparam int B  = 4;
  localparam int BL = 434;
  localparam int LAT_A = 2 + 7 * (11 * B + 2) + 11 * B;    // 368
  localparam int LAT_B = 2 + 7 * (11 * BL + 2) + 11 * BL;  // 38208

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic rst_a = 1'b0, rst_b = 1'b0;
  logic partida_a = 1'b0, partida_b = 1'b0;
  logic [3:0] ac_a, ad_a, au_a, mc_a, md_a, mu_a;
  logic [3:0] ac_b, ad_b, au_b, mc_b, md_b, mu_b;
  logic ser_a, ocup_a, pronto_a, ser_b, ocup_b, pronto_b;
  logic [3:0] est_a, est_b;

  tx_medida_serial #(.BAUD_DIV(B)) dut_a (
    .clock(clock), .reset(rst_a), .partida(partida_a),
    .angulo_centena(ac_a), .angulo_dezena(ad_a), .angulo_unidade(au_a),
    .medida_centena(mc_a), .medida_dezena(md_a), .medida_unidade(mu_a),
    .saida_serial(ser_a), .ocupado(ocup_a), .pronto(pronto_a), .db_estado(est_a)
  );

  tx_medida_serial #(.BAUD_DIV(BL)) dut_b (
    .clock(clock), .reset(rst_b), .partida(partida_b),
    .angulo_centena(ac_b), .angulo_dezena(ad_b), .angulo_unidade(au_b),
    .medida_centena(mc_b), .medida_dezena(md_b), .medida_unidade(mu_b),
    .saida_serial(ser_b), .ocupado(ocup_b), .pronto(pronto_b), .db_estado(est_b)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_q2[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Expected {parity, 7 data bits} for an ASCII character
  function automatic logic [7:0] exp_char(input logic [7:0] c);
    return {^c[6:0], c[6:0]};
  endfunction

  task automatic push_str(input logic [63:0] s, input bit sel);
    logic [7:0] c;
    for (int i = 0; i < 8; i++) begin
      c = s[63 - 8*i -: 8];
      if (sel) exp_q2.push_back(exp_char(c));
      else     exp_q.push_back(exp_char(c));
    end
  endtask

  function automatic logic line_of(input bit sel);  return sel ? ser_b : ser_a;       endfunction
  function automatic logic rst_of(input bit sel);   return sel ? rst_b : rst_a;       endfunction
  function automatic logic pr_of(input bit sel);    return sel ? pronto_b : pronto_a; endfunction
  function automatic logic oc_of(input bit sel);    return sel ? ocup_b : ocup_a;     endfunction
  function automatic logic [3:0] est_of(input bit sel); return sel ? est_b : est_a;   endfunction

  // ---------------- UART monitor ----------------
  // Called on the negedge where the start bit is first seen; samples each
  // bit near its centre. Reset during the frame abandons it.
  task automatic get_frame(input int b, input bit sel, output logic [10:0] bits, output bit ok);
    ok = 1'b1;
    bits = '1;
    repeat (b / 2) begin
      @(negedge clock);
      if (rst_of(sel)) begin ok = 1'b0; return; end
    end
    bits[0] = line_of(sel);
    for (int j = 1; j < 11; j++) begin
      repeat (b) begin
        @(negedge clock);
        if (rst_of(sel)) begin ok = 1'b0; return; end
      end
      bits[j] = line_of(sel);
    end
  endtask

  task automatic monitor(input int b, input bit sel);
    logic [10:0] fr;
    bit ok;
    logic [7:0] e;
    forever begin
      @(negedge clock);
      if (!rst_of(sel) && line_of(sel) === 1'b0) begin
        get_frame(b, sel, fr, ok);
        if (ok) begin
          if ((sel ? exp_q2.size() : exp_q.size()) == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_frame_%0d: got 0x%0h, expected no frame", sel, fr);
          end else begin
            e = sel ? exp_q2.pop_front() : exp_q.pop_front();
            chk(sel ? "char_b" : "char_a", 32'({fr[8], fr[7:1]}), 32'(e));
            chk(sel ? "start_b" : "start_a", 32'(fr[0]), 32'd0);
            chk(sel ? "stops_b" : "stops_a", 32'(fr[10:9]), 32'd3);
          end
        end
      end
    end
  endtask

  initial monitor(B, 1'b0);
  initial monitor(BL, 1'b1);

  // ---------------- driver tasks ----------------
  task automatic set_dig(input bit sel, input logic [23:0] d);
    if (sel) {ac_b, ad_b, au_b, mc_b, md_b, mu_b} = d;
    else     {ac_a, ad_a, au_a, mc_a, md_a, mu_a} = d;
  endtask

  // One-cycle partida on instance A; returns k, the edge that samples it.
  // Leaves the caller at the negedge of cycle k+1.
  task automatic start_rec(input logic [23:0] d, output int k);
    set_dig(1'b0, d);
    partida_a = 1'b1;
    k = cyc + 1;
    @(negedge clock);
    partida_a = 1'b0;
    chk("registra_state", 32'(est_a), 32'd1);
    @(negedge clock);
    chk("carrega_state", 32'(est_a), 32'd2);
    chk("ocupado_k1", 32'(ocup_a), 32'd1);
  endtask

  // Waits for pronto, checks its cycle and that it lasts exactly one cycle.
  task automatic wait_pronto(input bit sel, input int k, input int lat, input int bound);
    int t = 0;
    while (pr_of(sel) !== 1'b1 && t < bound) begin
      @(negedge clock);
      t++;
    end
    if (t >= bound) begin
      n_cmp++; n_bad++;
      $display("FAIL pronto_timeout_%0d: got no pronto, expected pronto at k+%0d", sel, lat);
    end else begin
      chk("pronto_cycle", 32'(cyc - k), 32'(lat));
      chk("final_ocupado", 32'(oc_of(sel)), 32'd0);
      chk("final_state", 32'(est_of(sel)), 32'd5);
      @(negedge clock);
      chk("pronto_width", 32'(pr_of(sel)), 32'd0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [23:0] dig;   // ang c/d/u, med c/d/u
    logic [63:0] rec;   // expected record text
  } vec_t;
  vec_t tbl[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2, np;

    tbl[0] = '{24'h045123, "045,123#"};
    tbl[1] = '{24'h180050, "180,050#"};
    tbl[2] = '{24'h999000, "999,000#"};
    tbl[3] = '{24'hF01B72, "?01,?72#"};
    tbl[4] = '{24'h000000, "000,000#"};

    set_dig(1'b0, 24'h0);
    set_dig(1'b1, 24'h0);
    #1 rst_a = 1'b1; rst_b = 1'b1;
    repeat (2) @(negedge clock);
    chk("reset_outputs_a", 32'({ser_a, ocup_a, pronto_a, est_a}), 32'h40);
    chk("reset_outputs_b", 32'({ser_b, ocup_b, pronto_b, est_b}), 32'h40);
    rst_a = 1'b0; rst_b = 1'b0;

    // Idle with partida low
    repeat (100) begin
      @(negedge clock);
      chk("idle", 32'({ser_a, ocup_a, pronto_a, est_a}), 32'h40);
    end

    // Table records; digits jump to 9 at cycle k+3 to prove they were latched
    for (int i = 0; i < 5; i++) begin
      push_str(tbl[i].rec, 1'b0);
      start_rec(tbl[i].dig, k);
      @(negedge clock);
      set_dig(1'b0, 24'h999999);
      wait_pronto(1'b0, k, LAT_A, 1000);
      repeat (3) @(negedge clock);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
    end

    // Extra partida pulses during a record are ignored
    push_str("045,123#", 1'b0);
    start_rec(24'h045123, k);
    repeat (k + 9 - cyc) @(negedge clock);
    partida_a = 1'b1; @(negedge clock); partida_a = 1'b0;
    repeat (k + 199 - cyc) @(negedge clock);
    partida_a = 1'b1; @(negedge clock); partida_a = 1'b0;
    wait_pronto(1'b0, k, LAT_A, 1000);
    np = 0;
    repeat (400) begin
      @(negedge clock);
      if (pronto_a === 1'b1) np++;
    end
    chk("no_extra_pronto", 32'(np), 32'd0);
    chk("no_extra_frames", 32'(exp_q.size()), 32'd0);

    // partida held high: two back-to-back records
    push_str("045,123#", 1'b0);
    push_str("045,123#", 1'b0);
    partida_a = 1'b1;
    k = cyc + 1;
    wait_pronto(1'b0, k, LAT_A, 1000);   // returns at negedge of F+1
    partida_a = 1'b0;
    chk("b2b_registra", 32'(est_a), 32'd1);
    @(negedge clock);
    chk("b2b_idle_line", 32'(ser_a), 32'd1);
    @(negedge clock);
    chk("b2b_start_F3", 32'(ser_a), 32'd0);
    k2 = k + LAT_A + 1;
    wait_pronto(1'b0, k2, LAT_A, 1000);
    repeat (20) @(negedge clock);
    chk("b2b_back_idle", 32'(est_a), 32'd0);
    chk("b2b_frames", 32'(exp_q.size()), 32'd0);

    // Reset during data bit 3 of character 5 (cycles k+248..k+251)
    push_str("045,123#", 1'b0);
    start_rec(24'h045123, k);
    repeat (k + 249 - cyc) @(negedge clock);
    chk("pre_reset_bit", 32'({ocup_a, ser_a}), 32'h2);
    rst_a = 1'b1;
    #1;
    chk("mid_reset_outputs", 32'({ser_a, ocup_a, pronto_a, est_a}), 32'h40);
    exp_q.delete();
    repeat (2) @(negedge clock);
    rst_a = 1'b0;
    repeat (3) @(negedge clock);
    push_str(tbl[1].rec, 1'b0);
    start_rec(tbl[1].dig, k);
    wait_pronto(1'b0, k, LAT_A, 1000);
    repeat (3) @(negedge clock);
    chk("after_reset_record", 32'(exp_q.size()), 32'd0);

    // Full-rate instance: invalid tens digit of distance becomes '?'
    push_str("180,2?7#", 1'b1);
    set_dig(1'b1, 24'h1802A7);
    partida_b = 1'b1;
    k = cyc + 1;
    @(negedge clock);
    partida_b = 1'b0;
    repeat (2) @(negedge clock);
    chk("b_start_bit_begin", 32'(ser_b), 32'd0);
    repeat (433) @(negedge clock);
    chk("b_start_bit_end", 32'(ser_b), 32'd0);
    @(negedge clock);
    chk("b_first_data_bit", 32'(ser_b), 32'd1);
    wait_pronto(1'b1, k, LAT_B, 40000);
    repeat (3) @(negedge clock);
    chk("b_frames", 32'(exp_q2.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
